// File: rtl/mac_pkg.sv
// Shared definitions for the mac_row feeder: west-port instruction codes and FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_pkg;

  // Instruction codes presented on mac_row.inst_w
  localparam logic [1:0] INST_IDLE = 2'b00;
  localparam logic [1:0] INST_LOAD = 2'b01;
  localparam logic [1:0] INST_EXEC = 2'b10;

  // Job sequencer states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GAP   = 3'd2,
    ST_EXEC  = 3'd3,
    ST_DRAIN = 3'd4
  } feeder_state_t;

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous FIFO buffering weight/activation words ahead of the row sequencer.
// Latency: a word pushed in cycle t is visible on dout (poppable) from t+1; no bypass.
// Backpressure: full blocks pushes; pops on empty are ignored; a pop while full frees space next cycle.
//
// Ports: clk/reset (sync, active-high), push/din write side, pop/dout read side
// (dout is the head word, valid while !empty), full/empty status flags.
module feeder_fifo #(
  parameter int bw    = 4,
  parameter int depth = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [bw-1:0] din,
  input  logic          pop,
  output logic [bw-1:0] dout,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(depth);

  logic [bw-1:0] r_mem [depth];
  // One extra pointer bit distinguishes full from empty when the indices match
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;

  logic w_do_push;
  logic w_do_pop;

  assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign empty     = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;
  assign dout      = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/mac_row_feeder.sv
// Drives a mac_row west port with a kernel-load (col words) then execute (num_act words) job.
// Latency: start in cycle t -> LOAD at t+1, first inst_w=01 at t+2; done at t+1+col+1+num_act+col+1 best case.
// Backpressure: din_ready = FIFO not full; an empty FIFO during LOAD/EXEC inserts an idle bubble.
//
// Ports: clk, reset (sync, active-high); start/num_act job request; din/din_valid/din_ready
// word input stream; in_w/inst_w registered mac_row west port; busy (job in progress, through
// the done cycle); done (one-cycle pulse at end of drain).
module mac_row_feeder
  import mac_pkg::*;
#(
  parameter int bw     = 4,
  parameter int col    = 8,
  parameter int depth  = 16,
  parameter int cnt_bw = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_bw-1:0] num_act,
  input  logic [bw-1:0]     din,
  input  logic              din_valid,
  output logic              din_ready,
  output logic [bw-1:0]     in_w,
  output logic [1:0]        inst_w,
  output logic              busy,
  output logic              done
);

  localparam logic [cnt_bw-1:0] LOAD_LAST  = cnt_bw'(col - 1);
  localparam logic [cnt_bw-1:0] DRAIN_LAST = cnt_bw'(col);

  feeder_state_t     r_state;
  logic [cnt_bw-1:0] r_cnt;
  logic [cnt_bw-1:0] r_num;
  logic [bw-1:0]     r_in_w;
  logic [1:0]        r_inst_w;
  logic              r_busy;
  logic              r_done;

  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic [bw-1:0] w_head;
  logic          w_exec_last;

  assign din_ready   = !w_full;
  assign w_pop       = !w_empty && ((r_state == ST_LOAD) || (r_state == ST_EXEC));
  // Only evaluated in EXEC, where r_num is known to be nonzero
  assign w_exec_last = (r_cnt == (r_num - cnt_bw'(1)));

  feeder_fifo #(
    .bw   (bw),
    .depth(depth)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (din_valid),
    .din  (din),
    .pop  (w_pop),
    .dout (w_head),
    .full (w_full),
    .empty(w_empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_cnt    <= '0;
      r_num    <= '0;
      r_in_w   <= '0;
      r_inst_w <= INST_IDLE;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_inst_w <= INST_IDLE;
      r_done   <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          r_in_w <= '0;
          r_cnt  <= '0;
          // busy stays high through the cycle that shows done, then follows start
          r_busy <= start;
          if (start) begin
            r_num   <= num_act;
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_busy <= 1'b1;
          // Empty FIFO: inst_w falls to idle and in_w keeps its last value
          if (!w_empty) begin
            r_in_w   <= w_head;
            r_inst_w <= INST_LOAD;
            if (r_cnt == LOAD_LAST) begin
              r_cnt   <= '0;
              r_state <= ST_GAP;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_GAP: begin
          r_busy  <= 1'b1;
          r_cnt   <= '0;
          r_state <= (r_num == '0) ? ST_DRAIN : ST_EXEC;
        end
        ST_EXEC: begin
          r_busy <= 1'b1;
          if (!w_empty) begin
            r_in_w   <= w_head;
            r_inst_w <= INST_EXEC;
            if (w_exec_last) begin
              r_cnt   <= '0;
              r_state <= ST_DRAIN;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          r_busy <= 1'b1;
          // col+1 idle cycles let the last column finish before reporting done
          if (r_cnt == DRAIN_LAST) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_w   = r_in_w;
  assign inst_w = r_inst_w;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_mac_row_feeder.sv
// Directed bench for mac_row_feeder: reset, full job, bubbles, zero activations, FIFO full, mid-job reset.
// Latency: cycle k below means the interval after the k-th rising edge following the start cycle.
// Backpressure: exercised through FIFO fill and sparse input streams.
module tb_mac_row_feeder;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] num_act;
  logic [3:0] din;
  logic       din_valid;
  logic       din_ready;
  logic [3:0] in_w;
  logic [1:0] inst_w;
  logic       busy;
  logic       done;

  int errors = 0;
  int checks = 0;

  logic [1:0] tr_inst [64];
  logic [3:0] tr_in   [64];
  logic       tr_done [64];
  logic       tr_busy [64];
  logic       tr_rdy  [64];

  mac_row_feeder #(
    .bw(4), .col(8), .depth(16), .cnt_bw(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .num_act  (num_act),
    .din      (din),
    .din_valid(din_valid),
    .din_ready(din_ready),
    .in_w     (in_w),
    .inst_w   (inst_w),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [3:0] w);
    din       = w;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // Records n cycles of outputs into the trace arrays; start drops after the first edge
  task automatic capture(input int n);
    for (int k = 1; k <= n; k++) begin
      tick();
      start      = 1'b0;
      tr_inst[k] = inst_w;
      tr_in[k]   = in_w;
      tr_done[k] = done;
      tr_busy[k] = busy;
      tr_rdy[k]  = din_ready;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; num_act = 8'd3; din = 4'h0; din_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({inst_w, in_w, busy, done, din_ready} !== 9'b00_0000_001) begin
        errors++;
        $display("FAIL reset_hold k=%0d got inst=%0h in=%0h busy=%0b done=%0b rdy=%0b expected 0/0/0/0/1",
                 k, inst_w, in_w, busy, done, din_ready);
      end
    end
    reset = 1'b0; start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if ({inst_w, in_w, busy, done, din_ready} !== 9'b00_0000_001) begin
        errors++;
        $display("FAIL reset_idle k=%0d got inst=%0h in=%0h busy=%0b done=%0b rdy=%0b expected 0/0/0/0/1",
                 k, inst_w, in_w, busy, done, din_ready);
      end
    end
  endtask

  // 8 x D then 2 x 5, num_act=2: loads at 2..9, gap 10, execs 11..12, done 21
  task automatic test_basic_job();
    logic [1:0] e_inst;
    logic [3:0] e_in;
    for (int i = 0; i < 8; i++) push_word(4'hD);
    for (int i = 0; i < 2; i++) push_word(4'h5);
    num_act = 8'd2; start = 1'b1;
    capture(24);
    for (int k = 1; k <= 24; k++) begin
      e_inst = (k >= 2 && k <= 9) ? 2'b01 : (k == 11 || k == 12) ? 2'b10 : 2'b00;
      e_in   = (k >= 2 && k <= 9) ? 4'hD : 4'h5;
      checks++;
      if (tr_inst[k] !== e_inst) begin
        errors++;
        $display("FAIL basic_inst k=%0d got=%0h expected=%0h", k, tr_inst[k], e_inst);
      end
      if (e_inst != 2'b00) begin
        checks++;
        if (tr_in[k] !== e_in) begin
          errors++;
          $display("FAIL basic_in_w k=%0d got=%0h expected=%0h", k, tr_in[k], e_in);
        end
      end
      if (k == 1 || k >= 22) begin
        checks++;
        if (tr_in[k] !== 4'h0) begin
          errors++;
          $display("FAIL basic_idle_in_w k=%0d got=%0h expected=0", k, tr_in[k]);
        end
      end
      checks++;
      if (tr_done[k] !== (k == 21)) begin
        errors++;
        $display("FAIL basic_done k=%0d got=%0b expected=%0b", k, tr_done[k], (k == 21));
      end
      checks++;
      if (tr_busy[k] !== (k <= 21)) begin
        errors++;
        $display("FAIL basic_busy k=%0d got=%0b expected=%0b", k, tr_busy[k], (k <= 21));
      end
    end
  endtask

  // One word every 3 cycles from the start cycle: loads 2,5..23, execs 26,29,32, done 41
  task automatic test_bubbles();
    logic [3:0] words [11];
    logic [1:0] e_inst;
    logic [3:0] e_in;
    int idx;
    for (int i = 0; i < 8; i++) words[i] = 4'(i + 1);
    words[8] = 4'hA; words[9] = 4'hB; words[10] = 4'hC;
    num_act = 8'd3; start = 1'b1;
    din = words[0]; din_valid = 1'b1; idx = 1;
    for (int n = 1; n <= 45; n++) begin
      tick();
      start = 1'b0;
      e_inst = 2'b00;
      e_in   = 4'h0;
      if (n >= 2 && n <= 23 && ((n - 2) % 3) == 0) begin
        e_inst = 2'b01; e_in = words[(n - 2) / 3];
      end else if (n == 26 || n == 29 || n == 32) begin
        e_inst = 2'b10; e_in = words[8 + (n - 26) / 3];
      end
      checks++;
      if (inst_w !== e_inst) begin
        errors++;
        $display("FAIL bubble_inst n=%0d got=%0h expected=%0h", n, inst_w, e_inst);
      end
      if (e_inst != 2'b00) begin
        checks++;
        if (in_w !== e_in) begin
          errors++;
          $display("FAIL bubble_in_w n=%0d got=%0h expected=%0h", n, in_w, e_in);
        end
      end
      checks++;
      if (done !== (n == 41) || busy !== (n <= 41)) begin
        errors++;
        $display("FAIL bubble_done_busy n=%0d got done=%0b busy=%0b expected done=%0b busy=%0b",
                 n, done, busy, (n == 41), (n <= 41));
      end
      if ((n % 3) == 0 && idx < 11) begin
        din = words[idx]; din_valid = 1'b1; idx++;
      end else begin
        din_valid = 1'b0;
      end
    end
    din_valid = 1'b0;
  endtask

  // num_act=0: loads 2..9, then only idle, done 19
  task automatic test_num_act_zero();
    logic [1:0] e_inst;
    for (int i = 0; i < 8; i++) push_word(4'h3);
    num_act = 8'd0; start = 1'b1;
    capture(24);
    for (int k = 1; k <= 24; k++) begin
      e_inst = (k >= 2 && k <= 9) ? 2'b01 : 2'b00;
      checks++;
      if (tr_inst[k] !== e_inst || (e_inst == 2'b01 && tr_in[k] !== 4'h3)) begin
        errors++;
        $display("FAIL zero_inst k=%0d got inst=%0h in=%0h expected inst=%0h in=3",
                 k, tr_inst[k], tr_in[k], e_inst);
      end
      checks++;
      if (tr_done[k] !== (k == 19) || tr_busy[k] !== (k <= 19)) begin
        errors++;
        $display("FAIL zero_done_busy k=%0d got done=%0b busy=%0b expected done=%0b busy=%0b",
                 k, tr_done[k], tr_busy[k], (k == 19), (k <= 19));
      end
    end
  endtask

  // Fill 16 words (values 0..15), 17th (7) dropped; num_act=8 job drains them in order
  task automatic test_fifo_full();
    logic [1:0] e_inst;
    logic [3:0] e_in;
    for (int i = 0; i < 16; i++) begin
      push_word(4'(i));
      checks++;
      if (din_ready !== (i < 15)) begin
        errors++;
        $display("FAIL full_ready after push %0d got=%0b expected=%0b", i + 1, din_ready, (i < 15));
      end
    end
    push_word(4'h7);
    checks++;
    if (din_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready_17th got=%0b expected=0", din_ready);
    end
    num_act = 8'd8; start = 1'b1;
    capture(30);
    checks++;
    if (tr_rdy[1] !== 1'b0 || tr_rdy[2] !== 1'b1) begin
      errors++;
      $display("FAIL full_ready_release got k1=%0b k2=%0b expected k1=0 k2=1", tr_rdy[1], tr_rdy[2]);
    end
    for (int k = 1; k <= 30; k++) begin
      e_inst = (k >= 2 && k <= 9) ? 2'b01 : (k >= 11 && k <= 18) ? 2'b10 : 2'b00;
      e_in   = (k <= 9) ? 4'(k - 2) : 4'(k - 3);
      checks++;
      if (tr_inst[k] !== e_inst || (e_inst != 2'b00 && tr_in[k] !== e_in)) begin
        errors++;
        $display("FAIL full_drain k=%0d got inst=%0h in=%0h expected inst=%0h in=%0h",
                 k, tr_inst[k], tr_in[k], e_inst, e_in);
      end
    end
    checks++;
    if (tr_done[27] !== 1'b1 || tr_done[26] !== 1'b0 || tr_busy[28] !== 1'b0) begin
      errors++;
      $display("FAIL full_done got done26=%0b done27=%0b busy28=%0b expected 0/1/0",
               tr_done[26], tr_done[27], tr_busy[28]);
    end
  endtask

  // Reset during EXEC, then an empty-FIFO job proves the leftovers were discarded
  task automatic test_reset_mid_job();
    logic [1:0] e_inst;
    for (int i = 0; i < 8; i++) push_word(4'h2);
    for (int i = 0; i < 4; i++) push_word(4'hB);
    num_act = 8'd4; start = 1'b1;
    capture(11);
    checks++;
    if (tr_inst[11] !== 2'b10 || tr_in[11] !== 4'hB) begin
      errors++;
      $display("FAIL midreset_pre got inst=%0h in=%0h expected inst=2 in=b", tr_inst[11], tr_in[11]);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({inst_w, in_w, busy, done, din_ready} !== 9'b00_0000_001) begin
      errors++;
      $display("FAIL midreset_outputs got inst=%0h in=%0h busy=%0b done=%0b rdy=%0b expected 0/0/0/0/1",
               inst_w, in_w, busy, done, din_ready);
    end
    reset = 1'b0;
    tick();
    // New job with nothing pushed until cycle 5; extra start pulses at 2,3 must be ignored
    num_act = 8'd1; start = 1'b1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      e_inst = (n >= 7 && n <= 14) ? 2'b01 : (n == 16) ? 2'b10 : 2'b00;
      checks++;
      if (inst_w !== e_inst || (n >= 7 && n <= 14 && in_w !== 4'h6) || (n == 16 && in_w !== 4'h9)) begin
        errors++;
        $display("FAIL midreset_job n=%0d got inst=%0h in=%0h expected inst=%0h", n, inst_w, in_w, e_inst);
      end
      checks++;
      if (done !== (n == 25) || busy !== (n <= 25)) begin
        errors++;
        $display("FAIL midreset_done_busy n=%0d got done=%0b busy=%0b expected done=%0b busy=%0b",
                 n, done, busy, (n == 25), (n <= 25));
      end
      start     = (n == 2 || n == 3);
      num_act   = (n == 2 || n == 3) ? 8'd5 : 8'd1;
      din_valid = (n >= 5 && n <= 13);
      din       = (n < 13) ? 4'h6 : 4'h9;
    end
    din_valid = 1'b0;
    start     = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_bubbles();
    test_num_act_zero();
    test_fifo_full();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mac_row_feeder.md
# mac_row_feeder

Sequencer that drives the west-side instruction/data port (`in_w`, `inst_w`) of a `mac_row` from a buffered stream of 4-bit words. It accepts a kernel-load-then-execute job through `start`. It then emits `col` weight-load cycles, one idle separator cycle, `num_act` execute cycles, and finally idle drain cycles until the row's last column has produced its result. It sits between the activation/weight memory read path and one systolic row.

## Interface
- `bw`, 4, width of weight/activation word (matches `mac_row` `in_w`)
- `col`, 8, number of columns in the driven row
- `depth`, 16, input FIFO entries (power of two, ≥2)
- `cnt_bw`, 8, width of `num_act`
- `clk`  input  1  clock, all logic on rising edge
- `reset`  input  1  synchronous, active-high; clears state, counters, FIFO, outputs
- `start`  input  1  job request; accepted only in IDLE
- `num_act`  input  cnt_bw  activations to stream in EXEC; sampled when `start` accepted
- `din`  input  bw  weight/activation word
- `din_valid`  input  1  `din` valid
- `din_ready`  output  1  FIFO not full (= !full)
- `in_w`  output  bw  to `mac_row.in_w`, registered
- `inst_w`  output  2  to `mac_row.inst_w`, registered; 00 idle, 01 load kernel, 10 execute
- `busy`  output  1  state ≠ IDLE
- `done`  output  1  one-cycle pulse at end of DRAIN

## Operation
- FIFO: push when `din_valid && din_ready`; pop when the FSM consumes a word. No bypass, so a word pushed in cycle t is first poppable in t+1. Push and pop in the same cycle when not full leave the count unchanged.
- FSM states IDLE → LOAD → GAP → EXEC → DRAIN → IDLE.
- IDLE: `inst_w`=00, `in_w`=0. On `start`, latch `num_act` and go to LOAD with the load counter at 0.
- LOAD: each cycle the FIFO is non-empty, pop, drive `in_w`=word, `inst_w`=01, and increment the counter. When the FIFO is empty, drive a bubble (`inst_w`=00, `in_w` holds its last value). After `col` pops, go to GAP.
- GAP: exactly one cycle of `inst_w`=00. Go to EXEC, or to DRAIN if the latched `num_act`=0.
- EXEC: same as LOAD but with `inst_w`=10, for `num_act` pops. Empty FIFO gives bubbles. Then go to DRAIN.
- DRAIN: `col`+1 cycles of `inst_w`=00. `done`=1 on the last DRAIN cycle's output register. Return to IDLE.
- `start` outside IDLE is ignored (no queuing).
- Counters saturate at their target; no wrap-around.
- Reset mid-job: the next cycle is IDLE, all outputs are 0, the FIFO is empty, and in-flight data is discarded.

## Timing
- Reset values: `in_w`=0, `inst_w`=00, `busy`=0, `done`=0, `din_ready`=1.
- `start` in cycle t puts the FSM in LOAD at t+1. With the FIFO pre-filled, the first `inst_w`=01 appears at the output register in t+2.
- Best-case job length: 1 (accept) + `col` + 1 + `num_act` + (`col`+1) cycles to the `done` pulse.
- `busy` is asserted from t+1 through the `done` cycle inclusive.
- `din_ready` is combinational from the FIFO count. Full: `din_ready`=0, and a simultaneous pop does not re-enable ready until the next cycle.
- Every bubble extends the job by exactly one cycle. The order and count of non-idle instructions are unaffected.

## Structure
- Shared package `mac_pkg`:
  - `INST_IDLE`=2'b00, `INST_LOAD`=2'b01, `INST_EXEC`=2'b10
  - FSM state encoding
- One sub-module, `feeder_fifo`: synchronous FIFO with parameters `bw` and `depth`, pointer wrap via log2(depth)+1-bit pointers, and full/empty flags.
- The FSM and counters live in `mac_row_feeder`.

## Test plan
- Reset then idle → `inst_w`=00, `in_w`=0, `din_ready`=1, `busy`=0 for 5 cycles; `start` pulsed during reset has no effect.
- FIFO pre-filled with eight 4'hD then two 4'h5, `num_act`=2, `start` → 8 cycles of (01, D), 1 cycle 00, 2 cycles of (10, 5), 9 cycles 00, `done` pulse. With a `mac_row` attached and `in_n`=16'h000A, column 0 `out_s` = 16'hFFFB (-5).
- Stream only one word every 3 cycles during LOAD/EXEC → bubbles inserted; exactly 8 loads and `num_act` execs; `done` delayed by the bubble count.
- `num_act`=0 → LOAD(8), GAP, DRAIN(9), `done`; no 10 is ever issued.
- Push 16 words with no job → `din_ready`=0 after the 16th; the 17th word is dropped. A job then drains it and `din_ready` returns 1 one cycle after the first pop.
- Assert `reset` in the middle of EXEC → next cycle all outputs are 0 and the FIFO is empty. A new `start` then runs a clean job, and `start` pulses during `busy` are ignored.
